muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit, parametrised in data width; sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake and returns the result through a second valid/ready handshake.
- Carries an opaque tag (destination register index) from input to output so the pipeline can write back on completion.
- Handles the RISC-V M-extension corner cases (divide by zero, signed overflow) in a fast path.

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// Accepts one op at a time, carries a writeback tag, and resolves
// divide-by-zero and signed-overflow divides without iterating.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The input side (in_valid/in_ready) only transfers in IDLE and never while
// flush is high. The output side holds out_valid, out and tag_out steady
// until out_ready is seen, and the unit only reopens in_ready on the cycle
// after that transfer.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] input0,
  input  logic [DATA_WIDTH-1:0] input1,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [TAG_WIDTH-1:0]  tag_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // opa holds the multiplicand, or the dividend magnitude that shifts into
  // the quotient during a divide; opb holds the multiplier or divisor magnitude.
  logic [W-1:0]     opa, opb, rem;
  logic [1:0]       op_lo;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  // Request decode, including the fast-path divides
  logic         accept, in_signed, dvz, ovf, special;
  logic [W-1:0] special_res, a_mag, b_mag;

  assign accept      = in_valid && (state == S_IDLE) && !flush;
  assign in_signed   = !funct3[0];
  assign dvz         = (input1 == '0);
  assign ovf         = in_signed && (input0 == MIN_NEG) && (input1 == '1);
  assign special     = funct3[2] && (dvz || ovf);
  assign special_res = dvz ? (funct3[1] ? input0 : '1) : (funct3[1] ? '0 : input0);
  assign a_mag       = (in_signed && input0[W-1]) ? -input0 : input0;
  assign b_mag       = (in_signed && input1[W-1]) ? -input1 : input1;

  // Multiply: sign-extend each operand to 2W bits as the op demands;
  // the low 2W bits of the product are exact for every signedness mix.
  logic           a_s, b_s;
  logic [2*W-1:0] a_x, b_x, prod;
  logic [W-1:0]   mul_res;

  assign a_s     = (op_lo == 2'b01) || (op_lo == 2'b10);
  assign b_s     = (op_lo == 2'b01);
  assign a_x     = {{W{a_s && opa[W-1]}}, opa};
  assign b_x     = {{W{b_s && opb[W-1]}}, opb};
  assign prod    = a_x * b_x;
  assign mul_res = (op_lo == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];

  // Restoring divide step: trial-subtract the divisor from the shifted
  // partial remainder; a clear borrow bit means the quotient bit is 1.
  logic [W:0]   r_sh, diff;
  logic [W-1:0] q_fix, r_fix;

  assign r_sh  = {rem, opa[W-1]};
  assign diff  = r_sh - {1'b0, opb};
  assign q_fix = neg_q ? -opa : opa;
  assign r_fix = neg_r ? -rem : rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs; flush returns to IDLE from anywhere
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          if (!funct3[2])   state_nx = S_MUL;
          else if (special) state_nx = S_DONE;
          else              state_nx = S_DIV;
        end
      end
      S_MUL: state_nx = S_DONE;
      S_DIV: if (cnt == CW'(W - 1)) state_nx = S_FIX;
      S_FIX: state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // Datapath: operand capture, iteration, and result/tag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      rem     <= '0;
      op_lo   <= '0;
      tag_q   <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      out     <= '0;
      tag_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_lo <= funct3[1:0];
            tag_q <= tag_in;
            cnt   <= '0;
            rem   <= '0;
            opa   <= funct3[2] ? a_mag : input0;
            opb   <= funct3[2] ? b_mag : input1;
            neg_q <= in_signed && (input0[W-1] ^ input1[W-1]);
            neg_r <= in_signed && input0[W-1];
            if (special) begin
              out     <= special_res;
              tag_out <= tag_in;
            end
          end
        end
        S_MUL: begin
          out     <= mul_res;
          tag_out <= tag_q;
        end
        S_DIV: begin
          opa <= {opa[W-2:0], ~diff[W]};
          rem <= diff[W] ? r_sh[W-1:0] : diff[W-1:0];
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          out     <= op_lo[1] ? r_fix : q_fix;
          tag_out <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: one 32-bit and one 16-bit instance share the
// stimulus; sel routes in_valid to one of them and muxes its outputs back.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, sel;
  logic [2:0]  funct3;
  logic [31:0] input0, input1;
  logic [4:0]  tag_in;

  logic        ir32, ov32, ir16, ov16, iv32, iv16;
  logic [31:0] out32;
  logic [15:0] out16;
  logic [4:0]  tag32, tag16;

  logic        ir, ov;
  logic [31:0] out_m;
  logic [4:0]  tag_m;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  assign iv32  = in_valid && !sel;
  assign iv16  = in_valid && sel;
  assign ir    = sel ? ir16 : ir32;
  assign ov    = sel ? ov16 : ov32;
  assign out_m = sel ? {16'h0, out16} : out32;
  assign tag_m = sel ? tag16 : tag32;

  muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .funct3(funct3), .input0(input0), .input1(input1), .tag_in(tag_in),
    .out_valid(ov32), .out_ready(out_ready), .out(out32), .tag_out(tag32)
  );

  muldiv_unit #(.DATA_WIDTH(16), .TAG_WIDTH(5)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv16), .in_ready(ir16),
    .funct3(funct3), .input0(input0[15:0]), .input1(input1[15:0]), .tag_in(tag_in),
    .out_valid(ov16), .out_ready(out_ready), .out(out16), .tag_out(tag16)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_res(int w, logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask, ua, ub, pu, res;
    longint signed sa, sb, ps, minv;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    minv = -(longint'(1) << (w - 1));
    res  = 64'h0;
    case (f)
      3'b000: begin ps = sa * sb; res = 64'(ps) & mask; end
      3'b001: begin ps = sa * sb; res = 64'(ps >>> w) & mask; end
      3'b010: begin ps = sa * longint'(ub); res = 64'(ps >>> w) & mask; end
      3'b011: begin pu = ua * ub; res = (pu >> w) & mask; end
      3'b100: begin
        if (ub == 0) res = mask;
        else if (sa == minv && sb == -1) res = ua;
        else res = 64'(sa / sb) & mask;
      end
      3'b101: res = (ub == 0) ? mask : ua / ub;
      3'b110: begin
        if (ub == 0) res = ua;
        else if (sa == minv && sb == -1) res = 64'h0;
        else res = 64'(sa % sb) & mask;
      end
      default: res = (ub == 0) ? ua : ua % ub;
    endcase
    return res[31:0];
  endfunction

  function automatic int ref_lat(int w, logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask, ua, ub;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    if (!f[2]) return 2;
    if (ub == 0) return 1;
    if (!f[0] && ua == (64'd1 << (w - 1)) && ub == mask) return 1;
    return w + 2;
  endfunction

  function automatic logic [31:0] rnd_val(int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return m;
      2: return 32'h1 << (w - 1);
      3: return 32'($urandom_range(0, 10));
      default: return $urandom & m;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at (accepting edge)+1.
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t);
    int n = 0;
    while (!ir && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_send", {31'h0, ir}, 32'h1);
    funct3   = f;
    input0   = a;
    input1   = b;
    tag_in   = t;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic wait_result(output logic [31:0] o, output logic [4:0] t, output int lat);
    lat = 1;
    while (!ov && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    o = out_m;
    t = tag_m;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [31:0] o, r;
    logic [4:0]  t;
    int          lat, w, seen;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  tg;

    vecs[0]  = '{32, 3'b001, 32'hFFFF_FFFF, 32'h2, 5'd1, 32'hFFFF_FFFF, 2};
    vecs[1]  = '{32, 3'b011, 32'hFFFF_FFFF, 32'h2, 5'd2, 32'h1, 2};
    vecs[2]  = '{32, 3'b000, 32'h7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 2};
    vecs[3]  = '{32, 3'b100, 32'hFFFF_FFF9, 32'h2, 5'd4, 32'hFFFF_FFFD, 34};
    vecs[4]  = '{32, 3'b110, 32'hFFFF_FFF9, 32'h2, 5'd5, 32'hFFFF_FFFF, 34};
    vecs[5]  = '{32, 3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 34};
    vecs[6]  = '{32, 3'b101, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{32, 3'b110, 32'd5, 32'd0, 5'd8, 32'd5, 1};
    vecs[8]  = '{32, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1};
    vecs[9]  = '{32, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 1};
    vecs[10] = '{16, 3'b001, 32'hFFFF, 32'h2, 5'd11, 32'hFFFF, 2};
    vecs[11] = '{16, 3'b011, 32'hFFFF, 32'h2, 5'd12, 32'h1, 2};
    vecs[12] = '{16, 3'b000, 32'h7, 32'hFFFD, 5'd13, 32'hFFEB, 2};
    vecs[13] = '{16, 3'b100, 32'hFFF9, 32'h2, 5'd14, 32'hFFFD, 18};
    vecs[14] = '{16, 3'b110, 32'hFFF9, 32'h2, 5'd15, 32'hFFFF, 18};
    vecs[15] = '{16, 3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 18};
    vecs[16] = '{16, 3'b101, 32'd5, 32'd0, 5'd17, 32'hFFFF, 1};
    vecs[17] = '{16, 3'b110, 32'd5, 32'd0, 5'd18, 32'd5, 1};
    vecs[18] = '{16, 3'b100, 32'h8000, 32'hFFFF, 5'd19, 32'h8000, 1};
    vecs[19] = '{16, 3'b110, 32'h8000, 32'hFFFF, 5'd20, 32'h0, 1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    funct3 = '0; input0 = '0; input1 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state for both widths
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_in_ready", {31'h0, ir}, 32'h1);
      check("reset_out_valid", {31'h0, ov}, 32'h0);
      check("reset_out", out_m, 32'h0);
      check("reset_tag_out", {27'h0, tag_m}, 32'h0);
    end
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 20; i++) begin
      sel = (vecs[i].w == 16);
      send(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_result(o, t, lat);
      check("vec_out", o, vecs[i].exp);
      check("vec_tag", {27'h0, t}, {27'h0, vecs[i].tag});
      check("vec_latency", 32'(lat), 32'(vecs[i].lat));
      take();
      check("vec_ready_after", {31'h0, ir}, 32'h1);
    end

    // hand-written multi-cycle sequences, both widths
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      w   = sel ? 16 : 32;

      // backpressure on a completed divide
      send(3'b101, 32'd100, 32'd7, 5'h1A);
      wait_result(o, t, lat);
      check("bp_latency", 32'(lat), 32'(w + 2));
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check("bp_out_stable", out_m, 32'd14);
        check("bp_tag_stable", {27'h0, tag_m}, 32'h1A);
        check("bp_valid_held", {31'h0, ov}, 32'h1);
        check("bp_in_ready_low", {31'h0, ir}, 32'h0);
      end
      take();
      check("bp_in_ready_after", {31'h0, ir}, 32'h1);
      check("bp_valid_dropped", {31'h0, ov}, 32'h0);

      // flush in the middle of a divide
      send(3'b100, 32'd1000, 32'd3, 5'h03);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_in_ready", {31'h0, ir}, 32'h1);
      seen = 0;
      for (int c = 0; c < w + 6; c++) begin
        if (ov) seen++;
        @(posedge clk); #1;
      end
      check("flush_no_result", 32'(seen), 32'h0);
      send(3'b000, 32'd3, 32'd4, 5'h05);
      wait_result(o, t, lat);
      check("post_flush_mul", o, 32'd12);
      check("post_flush_tag", {27'h0, t}, 32'h05);
      check("post_flush_lat", 32'(lat), 32'h2);
      take();

      // request presented under flush is ignored
      funct3 = 3'b000; input0 = 32'd2; input1 = 32'd2; tag_in = 5'h07;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_blocks_accept", {31'h0, ir}, 32'h1);
      @(posedge clk); #1;
      check("flush_blocks_valid", {31'h0, ov}, 32'h0);

      // flush in DONE with out_ready high drops the result
      send(3'b000, 32'd5, 32'd5, 5'h09);
      wait_result(o, t, lat);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b0;
      check("flush_done_valid", {31'h0, ov}, 32'h0);
      check("flush_done_ready", {31'h0, ir}, 32'h1);

      // reset while a result waits
      send(3'b000, 32'd6, 32'd7, 5'h0B);
      wait_result(o, t, lat);
      check("rst_pre_valid", {31'h0, ov}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_done_valid", {31'h0, ov}, 32'h0);
      check("rst_done_out", out_m, 32'h0);
      check("rst_done_tag", {27'h0, tag_m}, 32'h0);
      check("rst_done_ready", {31'h0, ir}, 32'h1);
    end

    // randomized ops against the model, both widths
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      w   = sel ? 16 : 32;
      repeat (40) begin
        f  = 3'($urandom_range(0, 7));
        a  = rnd_val(w);
        b  = rnd_val(w);
        tg = 5'($urandom_range(0, 31));
        exp_q.push_back(ref_res(w, f, a, b));
        send(f, a, b, tg);
        wait_result(o, t, lat);
        r = exp_q.pop_front();
        check("rand_out", o, r);
        check("rand_tag", {27'h0, t}, {27'h0, tg});
        check("rand_latency", 32'(lat), 32'(ref_lat(w, f, a, b)));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        check("rand_hold", out_m, r);
        take();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
